if_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipeline: owns the program counter, reads instructions from the Ram2 program SRAM, predicts conditional branches with a 2-bit saturating branch history table, and drives the IF/ID pipeline register. It sits directly upstream of the ID decoder, supplying `instr`, `epc` and `pcplus1`. It consumes stall, flush and redirect commands from the hazard unit.

---
 rtl/if_stage.sv | 128 ++++++++++++
 tb/tb_if_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch: PC register, program-SRAM read, 2-bit BHT branch prediction, IF/ID register.
// Latency: one edge from PC to IF/ID; redirects land in PC at the same edge.
// Backpressure: hold_i freezes PC and IF/ID; flush_if_i overrides hold and loads a bubble.
module if_stage #(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter int          BHT_BITS = 4,
    parameter logic [15:0] NOP      = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold_i,
    input  logic        flush_if_i,
    input  logic        jr_i,
    input  logic [15:0] jr_addr_i,
    input  logic        prewrong_i,
    input  logic [15:0] redirect_addr_i,
    input  logic        upd_valid_i,
    input  logic [15:0] upd_pc_i,
    input  logic        upd_taken_i,
    output logic [17:0] Ram2Addr,
    inout  wire  [15:0] Ram2Data,
    output logic        Ram2OE,
    output logic        Ram2WE,
    output logic        Ram2EN,
    output logic [15:0] instr_o,
    output logic [15:0] epc_o,
    output logic [15:0] pcplus1_o,
    output logic        prediction_o
);

    localparam int BHT_N = 1 << BHT_BITS;

    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] epc_q, epc_d;
    logic [15:0] pcplus1_q, pcplus1_d;
    logic        pred_q, pred_d;
    logic [1:0]  bht_q [BHT_N];
    logic [1:0]  bht_d [BHT_N];

    logic [15:0] w;
    logic [15:0] pc_inc;
    logic [15:0] imm;
    logic [15:0] target;
    logic        is_b, is_cond, pred_taken;
    logic        unused_upd_bits;

    assign Ram2Data = {16{1'bz}};
    assign Ram2Addr = {2'b00, pc_q};
    assign Ram2OE   = ~rst;
    assign Ram2WE   = 1'b1;
    assign Ram2EN   = 1'b0;

    assign w       = Ram2Data;
    assign pc_inc  = pc_q + 16'd1;
    assign is_b    = (w[15:11] == 5'b00010);
    assign is_cond = (w[15:11] == 5'b00100) || (w[15:11] == 5'b00101) ||
                     (w[15:8] == 8'b01100000) || (w[15:8] == 8'b01100001);
    assign imm     = is_b ? {{5{w[10]}}, w[10:0]} : {{8{w[7]}}, w[7:0]};
    assign target  = pc_inc + imm;
    // Prediction reads the registered counter, so a same-cycle update is seen next cycle.
    assign pred_taken = is_b || (is_cond && bht_q[pc_q[BHT_BITS-1:0]][1]);

    assign unused_upd_bits = ^upd_pc_i[15:BHT_BITS];

    always_comb begin
        pc_d = pc_inc;
        if (prewrong_i)      pc_d = redirect_addr_i;
        else if (jr_i)       pc_d = jr_addr_i;
        else if (hold_i)     pc_d = pc_q;
        else if (pred_taken) pc_d = target;
    end

    always_comb begin
        instr_d   = w;
        epc_d     = pc_q;
        pcplus1_d = pc_inc;
        pred_d    = pred_taken;
        if (flush_if_i) begin
            instr_d   = NOP;
            epc_d     = 16'h0000;
            pcplus1_d = 16'h0000;
            pred_d    = 1'b0;
        end else if (hold_i) begin
            instr_d   = instr_q;
            epc_d     = epc_q;
            pcplus1_d = pcplus1_q;
            pred_d    = pred_q;
        end
    end

    always_comb begin
        for (int i = 0; i < BHT_N; i++) bht_d[i] = bht_q[i];
        if (upd_valid_i) begin
            if (upd_taken_i) begin
                if (bht_q[upd_pc_i[BHT_BITS-1:0]] != 2'b11)
                    bht_d[upd_pc_i[BHT_BITS-1:0]] = bht_q[upd_pc_i[BHT_BITS-1:0]] + 2'b01;
            end else begin
                if (bht_q[upd_pc_i[BHT_BITS-1:0]] != 2'b00)
                    bht_d[upd_pc_i[BHT_BITS-1:0]] = bht_q[upd_pc_i[BHT_BITS-1:0]] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q      <= PC_RESET;
            instr_q   <= NOP;
            epc_q     <= 16'h0000;
            pcplus1_q <= 16'h0000;
            pred_q    <= 1'b0;
            for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            epc_q     <= epc_d;
            pcplus1_q <= pcplus1_d;
            pred_q    <= pred_d;
            for (int i = 0; i < BHT_N; i++) bht_q[i] <= bht_d[i];
        end
    end

    assign instr_o      = instr_q;
    assign epc_o        = epc_q;
    assign pcplus1_o    = pcplus1_q;
    assign prediction_o = pred_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a combinational program-SRAM model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold_i, flush_if_i, jr_i, prewrong_i, upd_valid_i, upd_taken_i;
    logic [15:0] jr_addr_i, redirect_addr_i, upd_pc_i;
    logic [17:0] ram2_addr;
    wire  [15:0] ram2_data;
    logic        ram2_oe, ram2_we, ram2_en;
    logic [15:0] instr, epc, pcplus1;
    logic        pred;

    logic [15:0] mem [256];
    int          n_vec = 0;
    int          n_err = 0;

    assign ram2_data = mem[ram2_addr[7:0]];

    always #5 clk = ~clk;

    if_stage dut (
        .clk             (clk),
        .rst             (rst),
        .hold_i          (hold_i),
        .flush_if_i      (flush_if_i),
        .jr_i            (jr_i),
        .jr_addr_i       (jr_addr_i),
        .prewrong_i      (prewrong_i),
        .redirect_addr_i (redirect_addr_i),
        .upd_valid_i     (upd_valid_i),
        .upd_pc_i        (upd_pc_i),
        .upd_taken_i     (upd_taken_i),
        .Ram2Addr        (ram2_addr),
        .Ram2Data        (ram2_data),
        .Ram2OE          (ram2_oe),
        .Ram2WE          (ram2_we),
        .Ram2EN          (ram2_en),
        .instr_o         (instr),
        .epc_o           (epc),
        .pcplus1_o       (pcplus1),
        .prediction_o    (pred)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic jump(input logic [15:0] addr);
        jr_i = 1'b1; jr_addr_i = addr; flush_if_i = 1'b1;
        step();
        jr_i = 1'b0; flush_if_i = 1'b0;
    endtask

    task automatic upd8(input logic taken, input int n);
        upd_valid_i = 1'b1; upd_pc_i = 16'h0008; upd_taken_i = taken;
        for (int i = 0; i < n; i++) step();
        upd_valid_i = 1'b0;
    endtask

    // Refetch the BEQZ at PC 8 (target 7) and check the predicted direction.
    task automatic probe8(input string tag, input logic exp_pred);
        jump(16'h0008);
        step();
        check({tag, "_instr"}, {16'h0, instr}, {16'h0, 16'h20FE});
        check({tag, "_epc"}, {16'h0, epc}, 32'h8);
        check({tag, "_pred"}, {31'h0, pred}, {31'h0, exp_pred});
        check({tag, "_npc"}, {14'h0, ram2_addr}, exp_pred ? 32'h7 : 32'h9);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0800;
        mem[0] = 16'h4901; mem[1] = 16'h4902; mem[2] = 16'h4903; mem[3] = 16'h0800;
        mem[4] = 16'h1005;
        mem[8] = 16'h20FE;
        mem[8'h20] = 16'h4920;

        rst = 1'b0; hold_i = 1'b0; flush_if_i = 1'b0; jr_i = 1'b0; prewrong_i = 1'b0;
        upd_valid_i = 1'b0; upd_taken_i = 1'b0;
        jr_addr_i = 16'h0; redirect_addr_i = 16'h0; upd_pc_i = 16'h0;
        step(); step();
        check("rst_oe", {31'h0, ram2_oe}, 32'h1);
        check("rst_we", {31'h0, ram2_we}, 32'h1);
        check("rst_en", {31'h0, ram2_en}, 32'h0);
        check("rst_instr", {16'h0, instr}, 32'h0800);
        check("rst_epc", {16'h0, epc}, 32'h0);
        check("rst_pcp1", {16'h0, pcplus1}, 32'h0);
        check("rst_pred", {31'h0, pred}, 32'h0);
        check("rst_addr", {14'h0, ram2_addr}, 32'h0);

        rst = 1'b1;
        #1 check("run_oe", {31'h0, ram2_oe}, 32'h0);
        step();
        check("f0_instr", {16'h0, instr}, 32'h4901);
        check("f0_epc", {16'h0, epc}, 32'h0);
        check("f0_pcp1", {16'h0, pcplus1}, 32'h1);
        step();
        check("f1_instr", {16'h0, instr}, 32'h4902);
        check("f1_epc", {16'h0, epc}, 32'h1);
        check("f1_addr", {14'h0, ram2_addr}, 32'h2);

        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_addr", {14'h0, ram2_addr}, 32'h2);
            check("hold_instr", {16'h0, instr}, 32'h4902);
            check("hold_epc", {16'h0, epc}, 32'h1);
        end
        hold_i = 1'b0;
        step();
        check("f2_instr", {16'h0, instr}, 32'h4903);
        check("f2_epc", {16'h0, epc}, 32'h2);
        step();
        check("f3_instr", {16'h0, instr}, 32'h0800);
        check("f3_epc", {16'h0, epc}, 32'h3);
        step();
        check("b_instr", {16'h0, instr}, 32'h1005);
        check("b_epc", {16'h0, epc}, 32'h4);
        check("b_pcp1", {16'h0, pcplus1}, 32'h5);
        check("b_pred", {31'h0, pred}, 32'h1);
        check("b_target", {14'h0, ram2_addr}, 32'hA);
        step();
        check("bt_epc", {16'h0, epc}, 32'hA);

        probe8("beqz_init", 1'b0);
        upd8(1'b1, 2);
        probe8("beqz_t2", 1'b1);
        upd8(1'b1, 1);
        upd8(1'b0, 2);
        probe8("sat_hi", 1'b0);
        upd8(1'b0, 4);
        upd8(1'b1, 1);
        probe8("sat_lo", 1'b0);

        // Counter is 01: update on the fetch edge must not affect that fetch.
        jump(16'h0008);
        upd_valid_i = 1'b1; upd_pc_i = 16'h0008; upd_taken_i = 1'b1;
        step();
        upd_valid_i = 1'b0;
        check("coll_pred", {31'h0, pred}, 32'h0);
        check("coll_npc", {14'h0, ram2_addr}, 32'h9);
        probe8("coll_after", 1'b1);

        prewrong_i = 1'b1; redirect_addr_i = 16'h0020;
        jr_i = 1'b1; jr_addr_i = 16'h0040; flush_if_i = 1'b1;
        step();
        prewrong_i = 1'b0; jr_i = 1'b0; flush_if_i = 1'b0;
        check("mis_pc", {14'h0, ram2_addr}, 32'h20);
        check("mis_instr", {16'h0, instr}, 32'h0800);
        check("mis_epc", {16'h0, epc}, 32'h0);
        step();
        check("mis_epc2", {16'h0, epc}, 32'h20);
        check("mis_instr2", {16'h0, instr}, 32'h4920);

        jump(16'hFFFF);
        step();
        check("wrap_epc", {16'h0, epc}, 32'hFFFF);
        check("wrap_pcp1", {16'h0, pcplus1}, 32'h0);
        check("wrap_addr", {14'h0, ram2_addr}, 32'h0);

        jump(16'h0033);
        check("pre_rst_pc", {14'h0, ram2_addr}, 32'h33);
        hold_i = 1'b1; rst = 1'b0;
        upd_valid_i = 1'b1; upd_pc_i = 16'h0008; upd_taken_i = 1'b1;
        step();
        check("mrst_pc", {14'h0, ram2_addr}, 32'h0);
        check("mrst_instr", {16'h0, instr}, 32'h0800);
        check("mrst_epc", {16'h0, epc}, 32'h0);
        check("mrst_oe", {31'h0, ram2_oe}, 32'h1);
        upd_valid_i = 1'b0; hold_i = 1'b0; rst = 1'b1;
        step();
        check("mrst_f0", {16'h0, instr}, 32'h4901);
        check("mrst_f0epc", {16'h0, epc}, 32'h0);
        probe8("bht_reset", 1'b0);
        upd8(1'b1, 1);
        probe8("bht_reset01", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
